// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

    // Controller states of the serial adder.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned MIN_WIDTH = 1;
    localparam int unsigned MAX_WIDTH = 64;

    // Bit counter width; the extra bit keeps WIDTH=1 and powers of two representable.
    function automatic int unsigned cnt_width(input int unsigned width);
        return 32'($clog2(width)) + 32'd1;
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit adder cells: half_adder and the full_adder built from two of them.

// Half adder: sum and carry of two bits.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b;
    assign cout = a & b;
endmodule

// Full adder: two cascaded half adders with the partial carries OR-ed.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.a(a),  .b(b),   .sum(s0),  .cout(c0));
    half_adder u_ha1 (.a(s0), .b(cin), .sum(sum), .cout(c1));

    assign cout = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell reused LSB first, WIDTH cycles per add.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   shift_a;
    logic [WIDTH-1:0]   shift_b;
    logic [WIDTH-1:0]   sum_reg;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   sum_shift_c;

    // The single serial bit cell.
    full_adder u_fa (
        .a   (shift_a[0]),
        .b   (shift_b[0]),
        .cin (carry),
        .sum (fa_sum),
        .cout(fa_cout)
    );

    // Sum register with the new bit entering at the MSB.
    assign sum_shift_c = (sum_reg >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    // Controller, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            shift_a   <= '0;
            shift_b   <= '0;
            sum_reg   <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_a  <= a;
                        shift_b  <= b;
                        carry    <= cin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    carry   <= fa_cout;
                    shift_a <= shift_a >> 1;
                    shift_b <= shift_b >> 1;
                    sum_reg <= sum_shift_c;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        sum       <= sum_shift_c;
                        cout      <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf       <= carry ^ fa_cout;
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 and WIDTH=1 instances.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       in_valid, in_ready, out_valid, out_ready, cin, cout;
    logic [7:0] a, b, sum;
    logic       v1, rdy1, ov1, ordy1, a1, b1, cin1, s1, co1;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf, ovf1;
`endif

    int errors = 0;
    int checks = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum),
`ifdef SERIAL_ADDER_OVF_EN
        .cout(cout), .ovf(ovf)
`else
        .cout(cout)
`endif
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v1), .in_ready(rdy1),
        .a(a1), .b(b1), .cin(cin1),
        .out_valid(ov1), .out_ready(ordy1),
        .sum(s1),
`ifdef SERIAL_ADDER_OVF_EN
        .cout(co1), .ovf(ovf1)
`else
        .cout(co1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one WIDTH=8 add, measure latency, check result, consume it.
    task automatic do_op(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                         input logic xc, input logic [7:0] es, input logic ec, input logic eo);
        int lat;
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; a = xa; b = xb; cin = xc;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 20);
        check_eq({tag, "_latency"}, 64'(lat), 64'd8);
        check_eq({tag, "_sum"}, 64'(sum), 64'(es));
        check_eq({tag, "_cout"}, 64'(cout), 64'(ec));
`ifdef SERIAL_ADDER_OVF_EN
        check_eq({tag, "_ovf"}, 64'(ovf), 64'(eo));
`else
        if (eo === 1'bx) $display("unexpected ovf reference");
`endif
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, "_ready_back"}, 64'(in_ready), 64'd1);
        check_eq({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [8:0] exp_q[$];
        logic [8:0] e;
        logic [7:0] hold_sum;
        int         last_acc;
        int         lat;
        bit         reroll;

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        v1 = 1'b0; ordy1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_sum", 64'(sum), 64'd0);
        check_eq("rst_cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check_eq("rst_ovf", 64'(ovf), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors (sum, cout, signed overflow).
        do_op("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op("5a_33", 8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0, 1'b1);
        do_op("7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        do_op("80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        do_op("aa_55", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);

        // Backpressure in DONE with competing in_valid.
        in_valid = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq("bp_reach_done", 64'(out_valid), 64'd1);
        hold_sum = sum;
        check_eq("bp_sum", 64'(hold_sum), 64'h46);
        in_valid = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_hold_sum", 64'(sum), 64'h46);
            check_eq("bp_hold_cout", 64'(cout), 64'd0);
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
            check_eq("bp_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("bp_consumed", 64'(out_valid), 64'd0);
        check_eq("bp_in_ready_back", 64'(in_ready), 64'd1);
        @(negedge clk);
        check_eq("bp_no_ghost_op", 64'(in_ready), 64'd1);

        // Back-to-back with in_valid and out_ready held high.
        in_valid = 1'b1; out_ready = 1'b1;
        a = 8'($urandom_range(255)); b = 8'($urandom_range(255)); cin = 1'($urandom_range(1));
        last_acc = -1;
        reroll = 1'b0;
        for (int c = 0; c < 45; c++) begin
            if (reroll) begin
                a = 8'($urandom_range(255)); b = 8'($urandom_range(255)); cin = 1'($urandom_range(1));
                reroll = 1'b0;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("b2b_spurious", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("b2b_sum", 64'(sum), 64'(e[7:0]));
                    check_eq("b2b_cout", 64'(cout), 64'(e[8]));
                end
            end
            if (in_ready) begin
                exp_q.push_back(9'(a) + 9'(b) + 9'(cin));
                if (last_acc >= 0) check_eq("b2b_interval", 64'(c - last_acc), 64'd10);
                last_acc = c;
                reroll = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (out_valid && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("b2b_sum", 64'(sum), 64'(e[7:0]));
                check_eq("b2b_cout", 64'(cout), 64'(e[8]));
            end
            @(negedge clk);
        end
        check_eq("b2b_drained", 64'(exp_q.size()), 64'd0);
        out_ready = 1'b0;

        // Reset during RUN.
        in_valid = 1'b1; a = 8'h77; b = 8'h11; cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_sum", 64'(sum), 64'd0);
        check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
        repeat (10) @(negedge clk);
        check_eq("post_rst_no_result", 64'(out_valid), 64'd0);
        do_op("post_rst_10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

        // WIDTH=1 instance.
        check_eq("w1_in_ready", 64'(rdy1), 64'd1);
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0;
        check_eq("w1_busy", 64'(rdy1), 64'd0);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!ov1 && lat < 10);
        check_eq("w1_latency", 64'(lat), 64'd1);
        check_eq("w1_sum", 64'(s1), 64'd1);
        check_eq("w1_cout", 64'(co1), 64'd1);
`ifdef SERIAL_ADDER_OVF_EN
        check_eq("w1_ovf", 64'(ovf1), 64'd0);
`endif
        ordy1 = 1'b1;
        @(negedge clk);
        ordy1 = 1'b0;
        check_eq("w1_ready_back", 64'(rdy1), 64'd1);
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
        @(negedge clk);
        v1 = 1'b0;
        lat = 0;
        while (!ov1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_eq("w1b_sum", 64'(s1), 64'd1);
        check_eq("w1b_cout", 64'(co1), 64'd0);
        ordy1 = 1'b1;
        @(negedge clk);
        ordy1 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
